ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte from the FPGA to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Complements the existing PS/2 receive path on the same PS2C/PS2D lines. Board-level open-drain pads are driven by the two *_low outputs.
- Implements the full host request: inhibit, request-to-send, 11-edge device-clocked frame, ack check, and timeout.

Parameters:
- INHIBIT_CYC, 5000: mclk cycles PS2C is held low before request (100 us at 50 MHz).
- REQ_CYC, 100: mclk cycles both lines are held low before PS2C is released (2 us).
- TIMEOUT_CYC, 750000: maximum mclk cycles between device clock falling edges, and in WAIT_IDLE (15 ms).
- FILT_LEN, 8: consecutive equal samples needed to accept a PS2C level change.

Ports:
- mclk  in  1: system clock.
- rst_n  in  1: asynchronous active-low reset.
- tx_data  in  8: byte to send; captured on an accepted tx_start.
- tx_start  in  1: one-cycle request; accepted only when busy=0.
- ps2c_in  in  1: raw PS2C pad level.
- ps2d_in  in  1: raw PS2D pad level.
- ps2c_low  out  1: 1 pulls PS2C low; 0 releases it.
- ps2d_low  out  1: 1 pulls PS2D low; 0 releases it.
- busy  out  1: high from the accepted start until return to IDLE. The receive path ignores the bus while busy=1.
- done  out  1: one-cycle pulse when a transfer ends, on success or failure.
- error  out  1: valid with done. Holds its value until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0; state is IDLE; all counters are 0. Lines are released immediately, including mid-frame.
- Input conditioning:
  - ps2c_in and ps2d_in each pass through a 2-flop synchronizer.
  - PS2C then passes through a FILT_LEN glitch filter.
  - fall = one-cycle pulse on a filtered PS2C 1->0 transition.
- IDLE:
  - All lines released.
  - On tx_start, latch tx_data into the shift register and compute parity = ~^tx_data (odd).
  - Set busy=1, clear error, go to INHIBIT.
  - tx_start while busy=1 is ignored, with no side effects.
- INHIBIT: ps2c_low=1, ps2d_low=0 for INHIBIT_CYC cycles, then go to REQUEST.
- REQUEST:
  - ps2c_low=1, ps2d_low=1 (start bit) for REQ_CYC cycles.
  - Then release PS2C, clear bit_idx and the timeout counter, go to SEND.
- SEND (PS2C released):
  - On each fall, drive PS2D for the next bit and increment bit_idx.
  - Falls 1-8: data bits D0..D7, LSB first; ps2d_low = ~bit.
  - Fall 9: parity bit.
  - Fall 10: ps2d_low=0 (stop bit released), go to ACK.
- ACK (both lines released): on fall 11, sample the synchronized PS2D.
  - 0 = ack: go to WAIT_IDLE.
  - 1 = nack: set error=1, go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until filtered PS2C=1 and synchronized PS2D=1 in the same cycle.
  - Then pulse done, busy=0, go to IDLE.
- Timeout:
  - In SEND, ACK and WAIT_IDLE the counter increments every cycle and clears on each fall.
  - When it reaches TIMEOUT_CYC: release both lines, set error=1, pulse done, busy=0, go to IDLE.
  - Sticky error is not cleared by timeout.
- Latency:
  - PS2D changes on the cycle after fall is detected.
  - The total is 2 sync + FILT_LEN filter + 1 cycle after the pad edge.
  - This is well inside the device's half-period.
- done and error never assert in the same cycle as reset deassertion. Only one done pulse per accepted start.

Test Plan:
- Bench setup for all scenarios: INHIBIT_CYC=20, REQ_CYC=4, TIMEOUT_CYC=200, FILT_LEN=2. The device model clocks 11 falls at 40-cycle period, samples PS2D on rising edges, and acks low on fall 11.
- Send 0xED -> ps2c_low high for 20 cycles, then both lines low for 4 cycles. Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1. Then one done pulse, error=0, busy falls.
- Send 0x07 -> device sees parity=0. Send 0x00 -> device sees parity=1. Both end with error=0.
- Device holds PS2D high at fall 11 (nack) -> done with error=1; error stays 1 until the next tx_start.
- Device never clocks after the request -> exactly 200 cycles after PS2C release: done=1, error=1, both *_low=0, busy=0.
- tx_start=1 with 0x55 during SEND of 0xF4 -> ignored; device receives 0xF4 only, and one done pulse.
- rst_n=0 at fall 5 -> ps2c_low, ps2d_low, busy, done and error are 0 within the same cycle. After release, a new 0xFF send completes cleanly.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if : command handshake between a requester and the PS/2 host
// transmitter.
//   tx_data  [7:0] requester -> transmitter : byte to send
//   tx_start       requester -> transmitter : one-cycle send request
//   busy           transmitter -> requester : transfer in progress
//   done           transmitter -> requester : one-cycle end-of-transfer pulse
//   error          transmitter -> requester : outcome, valid with done
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx : PS/2 host-to-device transmitter. Sends one command byte to
// the device: clock inhibit, request-to-send, 11 device-clocked edges, ack
// check, wait for bus idle, with an inter-edge timeout.
//   mclk      in  : system clock
//   rst_n     in  : asynchronous active-low reset
//   tx_if     slave modport : tx_data/tx_start in, busy/done/error out
//   ps2c_in   in  : raw PS2C pad level
//   ps2d_in   in  : raw PS2D pad level
//   ps2c_low  out : 1 pulls PS2C low (open-drain pad control)
//   ps2d_low  out : 1 pulls PS2D low (open-drain pad control)
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned REQ_CYC     = 100,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic            mclk,
  input  logic            rst_n,
  ps2_host_tx_if.slave    tx_if,
  input  logic            ps2c_in,
  input  logic            ps2d_in,
  output logic            ps2c_low,
  output logic            ps2d_low
);

  // One shared counter times inhibit, request and the inter-edge timeout.
  localparam int unsigned MAX_A   = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned FILT_W  = $clog2(FILT_LEN + 1);

  localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0]  REQ_LAST     = CNT_W'(REQ_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         c_sync_q, c_sync_d;
  logic [1:0]         d_sync_q, d_sync_d;
  logic [FILT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic               c_filt_q, c_filt_d;
  logic               fall_q, fall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [8:0]         shift_q, shift_d;   // {parity, data}, shifted out LSB first
  logic               ps2c_low_q, ps2c_low_d;
  logic               ps2d_low_q, ps2d_low_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  // Input synchronizers and PS2C glitch filter with registered fall pulse.
  always_comb begin
    c_sync_d   = {c_sync_q[0], ps2c_in};
    d_sync_d   = {d_sync_q[0], ps2d_in};
    c_filt_d   = c_filt_q;
    filt_cnt_d = '0;
    if (c_sync_q[1] != c_filt_q) begin
      // Accept the new level only after FILT_LEN consecutive differing samples.
      if (filt_cnt_q == FILT_LAST) begin
        c_filt_d   = c_sync_q[1];
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
    fall_d = c_filt_q & ~c_filt_d;
  end

  // Next-state and registered-output logic of the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    ps2c_low_d = ps2c_low_q;
    ps2d_low_d = ps2d_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        ps2c_low_d = 1'b0;
        ps2d_low_d = 1'b0;
        busy_d     = 1'b0;
        cnt_d      = '0;
        bit_idx_d  = 4'd0;
        if (tx_if.tx_start) begin
          shift_d    = {odd_parity(tx_if.tx_data), tx_if.tx_data};
          busy_d     = 1'b1;
          error_d    = 1'b0;
          ps2c_low_d = 1'b1;
          state_d    = S_INHIBIT;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d      = '0;
          ps2d_low_d = 1'b1;   // start bit
          state_d    = S_REQUEST;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      S_REQUEST: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = 4'd0;
          ps2c_low_d = 1'b0;   // hand the clock to the device, start bit stays
          state_d    = S_SEND;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      S_SEND, S_ACK, S_WAIT_IDLE: begin
        if ((cnt_q == TIMEOUT_LAST) && !fall_q) begin
          // Device stopped clocking: abandon the transfer. Error is sticky.
          cnt_d      = '0;
          ps2c_low_d = 1'b0;
          ps2d_low_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          error_d    = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = fall_q ? '0 : (cnt_q + CNT_W'(1));
          case (state_q)
            S_SEND: begin
              if (fall_q) begin
                bit_idx_d = bit_idx_q + 4'd1;
                if (bit_idx_q == 4'd9) begin
                  ps2d_low_d = 1'b0;   // stop bit: line released
                  state_d    = S_ACK;
                end else begin
                  ps2d_low_d = ~shift_q[0];
                  shift_d    = {1'b0, shift_q[8:1]};
                end
              end else begin
                bit_idx_d = bit_idx_q;
              end
            end
            S_ACK: begin
              if (fall_q) begin
                error_d = d_sync_q[1] ? 1'b1 : error_q;
                state_d = S_WAIT_IDLE;
              end else begin
                state_d = S_ACK;
              end
            end
            S_WAIT_IDLE: begin
              if (c_filt_q && d_sync_q[1]) begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_WAIT_IDLE;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      default: begin
        ps2c_low_d = 1'b0;
        ps2d_low_d = 1'b0;
        busy_d     = 1'b0;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      c_sync_q   <= 2'b11;
      d_sync_q   <= 2'b11;
      filt_cnt_q <= '0;
      c_filt_q   <= 1'b1;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 9'd0;
      ps2c_low_q <= 1'b0;
      ps2d_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_sync_q   <= c_sync_d;
      d_sync_q   <= d_sync_d;
      filt_cnt_q <= filt_cnt_d;
      c_filt_q   <= c_filt_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ps2c_low_q <= ps2c_low_d;
      ps2d_low_q <= ps2d_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign ps2c_low    = ps2c_low_q;
  assign ps2d_low    = ps2d_low_q;
  assign tx_if.busy  = busy_q;
  assign tx_if.done  = done_q;
  assign tx_if.error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx : self-checking bench for ps2_host_tx. A behavioural PS/2
// device clocks the frame, records the bits it samples on rising edges and
// acks or nacks; the expected frame is built from the byte value alone.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
  localparam int unsigned INH = 20;
  localparam int unsigned REQ = 4;
  localparam int unsigned TMO = 200;
  localparam int unsigned FL  = 2;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;
  logic ps2c_in, ps2d_in, ps2c_low, ps2d_low;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int done_cnt = 0;
  logic err_at_done = 1'b0;

  ps2_host_tx_if tx_if ();

  // Open-drain bus: either side may pull a line low.
  assign ps2c_in = dev_c & ~ps2c_low;
  assign ps2d_in = dev_d & ~ps2d_low;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .REQ_CYC     (REQ),
    .TIMEOUT_CYC (TMO),
    .FILT_LEN    (FL)
  ) dut (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .tx_if    (tx_if.slave),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_low (ps2c_low),
    .ps2d_low (ps2d_low)
  );

  always #5 mclk = ~mclk;

  // Done-pulse monitor.
  always @(negedge mclk) begin
    if (tx_if.done) begin
      done_cnt    <= done_cnt + 1;
      err_at_done <= tx_if.error;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device should see it: start, D0..D7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge mclk);
    tx_if.tx_data  = b;
    tx_if.tx_start = 1'b1;
    @(negedge mclk);
    tx_if.tx_start = 1'b0;
    check("busy_after_start", 32'(tx_if.busy), 32'd1);
    check("error_clear_on_start", 32'(tx_if.error), 32'd0);
  endtask

  // Measure inhibit and request phases; returns on the first sample with PS2C released.
  task automatic wait_request();
    int n;
    int inh;
    int req;
    n = 0;
    while (!ps2c_low && n < 100) begin
      @(negedge mclk);
      n++;
    end
    inh = 0;
    while (ps2c_low && !ps2d_low && inh < 1000) begin
      inh++;
      @(negedge mclk);
    end
    req = 0;
    while (ps2c_low && ps2d_low && req < 1000) begin
      req++;
      @(negedge mclk);
    end
    check("inhibit_cycles", 32'(inh), 32'(INH));
    check("request_cycles", 32'(req), 32'(REQ));
  endtask

  // Device clocking: 40-cycle period, samples on rising edges, ack/nack at fall 11.
  task automatic clock_frame(input bit nack, input int abort_at, input int poke_at,
                             output logic [10:0] got);
    bit stop;
    stop = 1'b0;
    got  = '0;
    repeat (30) @(negedge mclk);
    got[0] = ps2d_in;
    for (int k = 1; k <= 11 && !stop; k++) begin
      dev_c = 1'b0;
      if (k == 11) dev_d = nack;
      if (k == abort_at) begin
        stop = 1'b1;
      end else begin
        if (k == poke_at) begin
          tx_if.tx_data  = 8'h55;
          tx_if.tx_start = 1'b1;
        end
        @(negedge mclk);
        tx_if.tx_start = 1'b0;
        repeat (19) @(negedge mclk);
        if (k <= 10) got[k] = ps2d_in;
        dev_c = 1'b1;
        repeat (20) @(negedge mclk);
        dev_d = 1'b1;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit nack, input int poke_at);
    int d0;
    logic [10:0] got;
    d0 = done_cnt;
    send(b);
    wait_request();
    clock_frame(nack, 0, poke_at, got);
    check("frame_bits", 32'(got), 32'(frame_of(b)));
    repeat (15) @(negedge mclk);
    check("one_done_pulse", 32'(done_cnt - d0), 32'd1);
    check("error_with_done", 32'(err_at_done), 32'(nack));
    check("error_held", 32'(tx_if.error), 32'(nack));
    check("busy_low_after", 32'(tx_if.busy), 32'd0);
    check("lines_released", 32'({ps2c_low, ps2d_low}), 32'd0);
  endtask

  initial begin
    int k;
    int d0;
    logic [10:0] got;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_start = 1'b0;

    // Reset state
    repeat (3) @(negedge mclk);
    check("rst_outputs", 32'({ps2c_low, ps2d_low, tx_if.busy, tx_if.done, tx_if.error}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    check("no_done_after_rst", 32'(done_cnt), 32'd0);

    // Directed bytes, then random bytes
    run_xfer(8'hED, 1'b0, 0);
    run_xfer(8'h07, 1'b0, 0);
    run_xfer(8'h00, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      run_xfer(8'($urandom_range(0, 255)), 1'b0, 0);
    end

    // Nack: error set and held while idle
    run_xfer(8'($urandom_range(0, 255)), 1'b1, 0);
    repeat (30) @(negedge mclk);
    check("error_sticky_idle", 32'(tx_if.error), 32'd1);

    // Timeout: device never clocks
    d0 = done_cnt;
    send(8'($urandom_range(0, 255)));
    wait_request();
    k = 0;
    while (k < 400) begin
      @(negedge mclk);
      k++;
      if (tx_if.done) break;
    end
    check("timeout_cycles", 32'(k), 32'(TMO));
    check("timeout_done", 32'(tx_if.done), 32'd1);
    check("timeout_error", 32'(tx_if.error), 32'd1);
    check("timeout_lines", 32'({ps2c_low, ps2d_low}), 32'd0);
    check("timeout_busy", 32'(tx_if.busy), 32'd0);
    repeat (10) @(negedge mclk);
    check("timeout_one_done", 32'(done_cnt - d0), 32'd1);

    // Start request during SEND is ignored
    run_xfer(8'hF4, 1'b0, 3);

    // Reset at fall 5 releases everything immediately
    d0 = done_cnt;
    send(8'hA5);
    wait_request();
    clock_frame(1'b0, 5, 0, got);
    #1 rst_n = 1'b0;
    #1;
    check("midframe_rst_outputs",
          32'({ps2c_low, ps2d_low, tx_if.busy, tx_if.done, tx_if.error}), 32'd0);
    @(negedge mclk);
    dev_c = 1'b1;
    dev_d = 1'b1;
    repeat (5) @(negedge mclk);
    rst_n = 1'b1;
    repeat (5) @(negedge mclk);
    check("no_done_from_rst", 32'(done_cnt - d0), 32'd0);
    check("no_error_from_rst", 32'(tx_if.error), 32'd0);
    run_xfer(8'hFF, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
